// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command queue: command word layout and sequencer states.
package spi_cmd_pkg;

    localparam int unsigned CMD_W = 24;
    localparam int unsigned RD_W  = 8;

    typedef struct packed {
        logic             rd;
        logic [CMD_W-1:0] data;
    } spi_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_e;

endpackage

// File: rtl/spi_cmd_queue_if.sv
// Requester-side handshake of the SPI command queue: command push, flush and readback return.
interface spi_cmd_queue_if;

    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_rd;
    logic [spi_cmd_pkg::CMD_W-1:0]   cmd_data;
    logic                            flush;
    logic                            rd_valid;
    logic [spi_cmd_pkg::RD_W-1:0]    rd_data;

    modport master (
        output cmd_valid, cmd_rd, cmd_data, flush,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_data, flush,
        output cmd_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/spi_cmd_fifo.sv
// Synchronous FIFO of SPI commands with flush; level carries one extra bit so full and empty differ.
module spi_cmd_fifo
    import spi_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)
(
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  spi_cmd_t               wr_cmd,
    output spi_cmd_t               rd_cmd,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] level_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    spi_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          push_en, pop_en;

    // Push into a full FIFO is legal only alongside a pop; flush wins over a same-cycle push.
    always_comb begin
        pop_en   = pop && (level_q != '0);
        push_en  = push && !flush && ((level_q != LW'(DEPTH)) || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wr_cmd;
    end

    assign rd_cmd      = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign level_nxt_c = level_d;

endmodule

// File: rtl/spi_cmd_queue.sv
// Buffers AD9517 SPI commands and replays them one at a time to spi_master, paced by spi_busy.
module spi_cmd_queue
    import spi_cmd_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned GAP_CYCLES  = 4
)
(
    input  logic                   clk,
    input  logic                   nrst,
    spi_cmd_queue_if.slave         cmd_if,
    output logic                   o_spi_wr_cmd,
    output logic                   o_spi_rd_cmd,
    output logic [CMD_W-1:0]       o_spi_wr_data,
    input  logic [RD_W-1:0]        i_spi_rd_data,
    input  logic                   i_spi_busy,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_idle,
    output logic                   o_err_timeout
);

    localparam int unsigned LW      = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cur_rd_q, cur_rd_d;
    logic [CMD_W-1:0] wr_data_q, wr_data_d;
    logic             wr_cmd_q, wr_cmd_d;
    logic             rd_cmd_q, rd_cmd_d;
    logic             rd_valid_q, rd_valid_d;
    logic [RD_W-1:0]  rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic             idle_q, idle_d;

    spi_cmd_t         push_cmd, head;
    logic             pop;
    logic [LW-1:0]    level, level_nxt;

    assign push_cmd = {cmd_if.cmd_rd, cmd_if.cmd_data};

    spi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .push        (cmd_if.cmd_valid && cmd_if.cmd_ready),
        .pop         (pop),
        .flush       (cmd_if.flush),
        .wr_cmd      (push_cmd),
        .rd_cmd      (head),
        .level       (level),
        .level_nxt_c (level_nxt)
    );

    // Sequencer: pop, one-cycle start pulse, wait busy up then down, enforce CS_n high time.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_rd_d   = cur_rd_q;
        wr_data_d  = wr_data_q;
        wr_cmd_d   = 1'b0;
        rd_cmd_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    wr_data_d = head.data;
                    cur_rd_d  = head.rd;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rd_cmd_d = cur_rd_q;
                wr_cmd_d = !cur_rd_q;
                cnt_d    = '0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_spi_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!i_spi_busy) begin
                    rd_valid_d = cur_rd_q;
                    if (cur_rd_q) rd_data_d = i_spi_rd_data;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        idle_d = (state_d == IDLE) && (level_nxt == '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_rd_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_cmd_q   <= 1'b0;
            rd_cmd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_rd_q   <= cur_rd_d;
            wr_data_q  <= wr_data_d;
            wr_cmd_q   <= wr_cmd_d;
            rd_cmd_q   <= rd_cmd_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end

    assign cmd_if.cmd_ready = (level != LW'(DEPTH));
    assign cmd_if.rd_valid  = rd_valid_q;
    assign cmd_if.rd_data   = rd_data_q;
    assign o_spi_wr_cmd     = wr_cmd_q;
    assign o_spi_rd_cmd     = rd_cmd_q;
    assign o_spi_wr_data    = wr_data_q;
    assign o_level          = level;
    assign o_idle           = idle_q;
    assign o_err_timeout    = err_q;

endmodule
